// File: rtl/fb_pixel_writer.sv
// Frame-buffer write-port feeder: accepts a valid/ready RGB stream or generates a
// constant fill, and turns each pixel into a registered raster-order write.
module fb_pixel_writer #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 24,
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_count,
    output logic [9:0]        cur_x,
    output logic [8:0]        cur_y
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FILL   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [9:0]        X_LAST   = 10'(IMG_W - 1);
    localparam logic [8:0]        Y_LAST   = 9'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [9:0]          x_q, x_d;
    logic [8:0]          y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   color_q, color_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic [7:0]          fc_q, fc_d;
    logic                s_ready_s;
    logic                wr_s;

    // Abort gates ready combinationally so nothing is accepted in the cancel cycle.
    assign s_ready_s = (state_q == S_STREAM) && !abort;
    assign wr_s      = (s_valid && s_ready_s) || ((state_q == S_FILL) && !abort);

    // Next-state, pixel position, running address and write-port registers.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        color_d     = color_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        fc_d        = fc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d    = 10'd0;
                    y_d    = 9'd0;
                    addr_d = {ADDR_W{1'b0}};
                    if (fill) begin
                        state_d = S_FILL;
                        color_d = fill_color;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM, S_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (wr_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = (state_q == S_FILL) ? color_q : s_data;
                    addr_d      = addr_q + ADDR_ONE;
                    // Address counter tracks y*IMG_W+x without a multiplier.
                    if (x_q == X_LAST) begin
                        x_d = 10'd0;
                        if (y_q == Y_LAST) begin
                            y_d     = 9'd0;
                            state_d = S_DONE;
                        end else begin
                            y_d = y_q + 9'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DONE: begin
                fc_d    = fc_q + 8'd1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any write in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= 10'd0;
            y_q         <= 9'd0;
            addr_q      <= {ADDR_W{1'b0}};
            color_q     <= {DATA_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_we_q    <= 1'b0;
            fc_q        <= 8'd0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            color_q     <= color_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            fc_q        <= fc_d;
        end
    end

    assign s_ready     = s_ready_s;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign busy        = (state_q == S_STREAM) || (state_q == S_FILL);
    assign done        = (state_q == S_DONE);
    assign frame_count = fc_q;
    assign cur_x       = x_q;
    assign cur_y       = y_q;

endmodule
